// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing and pixel-stream generator.
// A clock-enable prescaler produces pix_tick. The coordinate counters
// issue (req_x, req_y) to a pixel source. Decoded sync/visibility flags
// are delayed DATA_LATENCY ticks so that sync and RGB leave aligned
// with the pixel data returned by the source.
module vga_timing_gen #(
  parameter int H_DISPLAY    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_DISPLAY    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int CLK_DIV      = 2,
  parameter int SYNC_POL     = 0,
  parameter int DATA_LATENCY = 1,
  parameter int COLOR_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [3*COLOR_BITS-1:0] pixel_in,
  output logic                    pix_tick,
  output logic                    req,
  output logic [$clog2(H_DISPLAY+H_FRONT+H_SYNC+H_BACK)-1:0] req_x,
  output logic [$clog2(V_DISPLAY+V_FRONT+V_SYNC+V_BACK)-1:0] req_y,
  output logic                    line_start,
  output logic                    frame_start,
  output logic                    hsync,
  output logic                    vsync,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW      = 3 * COLOR_BITS;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_VIS    = XW'(H_DISPLAY);
  localparam logic [XW-1:0] X_HS0    = XW'(H_DISPLAY + H_FRONT);
  localparam logic [XW-1:0] X_HS1    = XW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_VIS    = YW'(V_DISPLAY);
  localparam logic [YW-1:0] Y_VS0    = YW'(V_DISPLAY + V_FRONT);
  localparam logic [YW-1:0] Y_VS1    = YW'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic          SYNC_IDLE = (SYNC_POL == 0);

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic x0;
    logic f0;
  } flags_t;

  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;
  logic          run_q, run_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [PW-1:0] rgb_q, rgb_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;
  flags_t        flags_now;
  flags_t        flags_dly;

  // Decode the current coordinate; run_q keeps req low while idle.
  always_comb begin
    flags_now.vis = run_q && (x_q < X_VIS) && (y_q < Y_VIS);
    flags_now.hs  = (x_q >= X_HS0) && (x_q < X_HS1);
    flags_now.vs  = (y_q >= Y_VS0) && (y_q < Y_VS1);
    flags_now.x0  = (x_q == '0);
    flags_now.f0  = (x_q == '0) && (y_q == '0);
  end

  // Prescaler and coordinate counters; enable low forces the idle state.
  always_comb begin
    div_d  = '0;
    tick_d = 1'b0;
    run_d  = enable;
    x_d    = '0;
    y_d    = '0;
    if (enable) begin
      tick_d = (div_q == DIV_LAST);
      div_d  = tick_d ? '0 : div_q + 1'b1;
      x_d    = x_q;
      y_d    = y_q;
      if (tick_q) begin
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
    end
  end

  // Flag delay line matching the pixel source latency.
  if (DATA_LATENCY == 0) begin : g_nodly
    assign flags_dly = flags_now;
  end else begin : g_dly
    flags_t [DATA_LATENCY-1:0] pipe_q, pipe_d;

    // Shift one stage per pixel tick; cleared while disabled.
    always_comb begin
      pipe_d = pipe_q;
      if (!enable) begin
        pipe_d = '0;
      end else if (tick_q) begin
        pipe_d[0] = flags_now;
        for (int unsigned i = 1; i < DATA_LATENCY; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end
    end

    // Delay line registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) pipe_q <= '0;
      else       pipe_q <= pipe_d;
    end

    assign flags_dly = pipe_q[DATA_LATENCY-1];
  end

  // Output registers load on pix_tick; line/frame pulses last one clk.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    if (!enable) begin
      hsync_d = SYNC_IDLE;
      vsync_d = SYNC_IDLE;
      rgb_d   = '0;
    end else if (tick_q) begin
      hsync_d = flags_dly.hs ^ SYNC_IDLE;
      vsync_d = flags_dly.vs ^ SYNC_IDLE;
      rgb_d   = flags_dly.vis ? pixel_in : '0;
      ls_d    = flags_dly.x0;
      fs_d    = flags_dly.f0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      run_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
      rgb_q   <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      run_q   <= run_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign pix_tick    = tick_q;
  assign req         = flags_now.vis;
  assign req_x       = x_q;
  assign req_y       = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = rgb_q[COLOR_BITS-1:0];
  assign green       = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
  assign blue        = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-geometry instances (CLK_DIV=1/latency 2,
// active-low sync; CLK_DIV=4/latency 0, active-high sync) driven with random
// pixel data and checked every clk against an arithmetic timing model.
module tb_vga_timing_gen;

  localparam int HD = 8, HF = 2, HS = 2, HB = 2, HT = 14;
  localparam int VD = 4, VF = 1, VS = 1, VB = 1, VT = 7;

  logic        clk = 1'b0;
  logic        rst, en_a, en_b;
  logic [11:0] pix_a, pix_b;

  logic       tick_a, req_a, ls_a, fs_a, hs_a, vs_a;
  logic [3:0] x_a, r_a, g_a, b_a;
  logic [2:0] y_a;
  logic       tick_b, req_b, ls_b, fs_b, hs_b, vs_b;
  logic [3:0] x_b, r_b, g_b, b_b;
  logic [2:0] y_b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(1), .SYNC_POL(0), .DATA_LATENCY(2), .COLOR_BITS(4)
  ) u_a (
    .clk(clk), .reset(rst), .enable(en_a), .pixel_in(pix_a),
    .pix_tick(tick_a), .req(req_a), .req_x(x_a), .req_y(y_a),
    .line_start(ls_a), .frame_start(fs_a), .hsync(hs_a), .vsync(vs_a),
    .red(r_a), .green(g_a), .blue(b_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(4), .SYNC_POL(1), .DATA_LATENCY(0), .COLOR_BITS(4)
  ) u_b (
    .clk(clk), .reset(rst), .enable(en_b), .pixel_in(pix_b),
    .pix_tick(tick_b), .req(req_b), .req_x(x_b), .req_y(y_b),
    .line_start(ls_b), .frame_start(fs_b), .hsync(hs_b), .vsync(vs_b),
    .red(r_b), .green(g_b), .blue(b_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Per-instance model parameters and state.
  int          dv  [2] = '{1, 4};
  int          dl  [2] = '{2, 0};
  int          pol [2] = '{0, 1};
  int          cc  [2];          // enabled clk edges since idle
  logic [11:0] rgb_e [2];        // expected colour register
  logic        en_s  [2];        // enable seen at the coming edge
  logic [11:0] pix_s [2];        // pixel_in seen at the coming edge

  function automatic bit visible(int j);
    return ((j % HT) < HD) && (((j / HT) % VT) < VD);
  endfunction

  // Expected pins from the number of enabled edges: ticks fall on every
  // dv-th edge; position j leaves the pins dl ticks after it was issued.
  function automatic logic [24:0] model_vec(int i);
    int   c, t, x, y, j, xj, yj;
    logic tk, rq, ls, fs, hact, vact, hsv, vsv;
    c  = cc[i];
    tk = (c >= 1) && (c % dv[i] == 0);
    t  = (c >= 1) ? (c - 1) / dv[i] : 0;
    x  = t % HT;
    y  = (t / HT) % VT;
    rq = (c >= 1) && (x < HD) && (y < VD);
    j  = t - 1 - dl[i];
    hact = 1'b0; vact = 1'b0; ls = 1'b0; fs = 1'b0;
    if (j >= 0) begin
      xj   = j % HT;
      yj   = (j / HT) % VT;
      hact = (xj >= HD + HF) && (xj < HD + HF + HS);
      vact = (yj >= VD + VF) && (yj < VD + VF + VS);
      if ((c >= 2) && ((c - 1) % dv[i] == 0) && (xj == 0)) begin
        ls = 1'b1;
        fs = (yj == 0);
      end
    end
    hsv = (pol[i] != 0) ? hact : !hact;
    vsv = (pol[i] != 0) ? vact : !vact;
    return {tk, rq, x[3:0], y[2:0], ls, fs, hsv, vsv, rgb_e[i]};
  endfunction

  function automatic logic [24:0] obs_vec(int i);
    if (i == 0)
      return {tick_a, req_a, x_a, y_a, ls_a, fs_a, hs_a, vs_a, b_a, g_a, r_a};
    return {tick_b, req_b, x_b, y_b, ls_b, fs_b, hs_b, vs_b, b_b, g_b, r_b};
  endfunction

  task automatic chk(string tag, int i);
    logic [24:0] obs, exp;
    obs = obs_vec(i);
    exp = model_vec(i);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic idle_model();
    for (int i = 0; i < 2; i++) begin
      cc[i]    = 0;
      rgb_e[i] = '0;
    end
  endtask

  // Advance the model across one clk edge.
  task automatic advance(int i);
    int j;
    if (rst || !en_s[i]) begin
      cc[i]    = 0;
      rgb_e[i] = '0;
    end else begin
      cc[i]++;
      if ((cc[i] >= 2) && ((cc[i] - 1) % dv[i] == 0)) begin
        j = (cc[i] - 1) / dv[i] - 1 - dl[i];
        rgb_e[i] = (j >= 0 && visible(j)) ? pix_s[i] : 12'h000;
      end
    end
  endtask

  task automatic cycle();
    en_s[0]  = en_a;
    en_s[1]  = en_b;
    pix_s[0] = pix_a;
    pix_s[1] = pix_b;
    @(posedge clk);
    #1;
    advance(0);
    advance(1);
    chk("inst_a", 0);
    chk("inst_b", 1);
    pix_a = 12'($urandom);
    pix_b = 12'($urandom);
  endtask

  initial begin
    int  t;
    bit  found;
    rst   = 1'b1;
    en_a  = 1'b0;
    en_b  = 1'b0;
    pix_a = 12'($urandom);
    pix_b = 12'($urandom);
    idle_model();

    // Reset state, then idle with enable low.
    repeat (3) cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // Free run: several frames of the fast instance, two of the slow one.
    en_a = 1'b1;
    en_b = 1'b1;
    repeat (900) cycle();

    // Enable dropped for 3 clks mid-frame on the divide-by-4 instance.
    en_b = 1'b0;
    repeat (3) cycle();
    en_b = 1'b1;
    repeat (300) cycle();

    // Asynchronous reset while instance a issues (5,2).
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      cycle();
      t = (cc[0] - 1) / dv[0];
      if (cc[0] >= 1 && (t % HT) == 5 && ((t / HT) % VT) == 2) found = 1'b1;
    end
    rst = 1'b1;
    #1;
    idle_model();
    chk("async_rst_a", 0);
    chk("async_rst_b", 1);
    repeat (2) cycle();
    rst = 1'b0;
    repeat (300) cycle();

    // Random enable gaps.
    repeat (600) begin
      en_a = ($urandom_range(0, 29) != 0);
      en_b = ($urandom_range(0, 29) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing and pixel-stream generator; successor to the fixed 640x480 sync/data-pipe pair.
- All porches, sync widths, sync polarity, pixel-clock divide and pixel-source latency are parameters.
- Runs from the system clock using a clock-enable prescaler; no derived clocks.
- Sits between a pixel source (frame buffer or pattern generator) and the VGA pins. It issues pixel coordinates and emits sync and RGB delayed by the same amount, so they stay aligned.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 2, clk cycles per pixel (1..16)
SYNC_POL, 0, sync active level (0 = active-low)
DATA_LATENCY, 1, pixel ticks from coordinate issue to pixel_in valid (0..4)
COLOR_BITS, 4, bits per colour channel

Ports:
clk  in  1  system clock, 50 MHz nominal
reset  in  1  asynchronous, active-high
enable  in  1  run when high; when low, hold idle
pixel_in  in  3*COLOR_BITS  {blue,green,red} from source, red in LSBs
pix_tick  out  1  one-clk pulse marking each pixel period
req  out  1  high while (req_x,req_y) is a visible position
req_x  out  $clog2(H_TOTAL)  horizontal counter
req_y  out  $clog2(V_TOTAL)  vertical counter
line_start  out  1  one-clk pulse, aligned to output stream, when output x==0
frame_start  out  1  one-clk pulse, aligned to output stream, when output x==0,y==0
hsync  out  1  VGA horizontal sync
vsync  out  1  VGA vertical sync
red, green, blue  out  COLOR_BITS each  VGA colour

Behaviour:
- Derived totals: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters. Line order is display, front, sync, back; frame order is the same.
- Reset (async): prescaler=0, req_x=0, req_y=0, pipeline cleared, pix_tick=0, req=0, line_start=0, frame_start=0, rgb=0, hsync=vsync=~SYNC_POL.
- Prescaler:
  - Counts 0..CLK_DIV-1 while enable.
  - pix_tick=1 for the single clk when count==CLK_DIV-1.
  - With CLK_DIV=1, pix_tick is constantly 1 while enabled.
- Counters (advance only on pix_tick):
  - req_x increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, req_y increments and wraps V_TOTAL-1 -> 0.
  - Values outside 0..TOTAL-1 never appear.
- Decode:
  - req = (req_x<H_DISPLAY)&&(req_y<V_DISPLAY); combinational from the registered counters.
  - hs_act = H_DISPLAY+H_FRONT <= req_x < H_DISPLAY+H_FRONT+H_SYNC.
  - vs_act is the same form using req_y and the V_* parameters.
- Alignment pipeline:
  - The decoded {req, hs_act, vs_act, x==0, x==0&&y==0} passes through a DATA_LATENCY-deep shift register clocked on pix_tick.
  - On pix_tick the output registers load: hsync = hs_act_d ^ ~SYNC_POL (likewise vsync); rgb = req_d ? pixel_in : 0.
  - Resulting contract: position (x,y) presented at tick k appears on the pins for the pixel period after tick k+DATA_LATENCY, with its own pixel_in.
  - DATA_LATENCY=0 means the source is combinational; pixel_in is sampled at tick k.
- Output pulses:
  - line_start and frame_start are high for the one clk of the pix_tick at which the delayed x==0 flag loads.
  - frame_start implies line_start.
- RGB in blanking is always 0, whatever pixel_in is.
- enable low:
  - Synchronous: next clk, prescaler, counters and pipeline go to 0 and outputs go to reset values.
  - The output stays idle while enable is low.
  - On re-enable, the first pix_tick occurs CLK_DIV clks later, and the frame restarts at (0,0).
- reset mid-frame: immediate idle. After release, timing restarts at (0,0) exactly as after enable rises; there is no partial-line output.
- pixel_in is ignored except when sampled on pix_tick with req_d=1.

Test Plan:
- Default parameters, CLK_DIV=2 -> hsync period 1600 clk, low for 192 clk; vsync low for 3200 clk; frame_start spacing exactly 840000 clk; 307200 visible pixels per frame.
- H=8/2/2/2, V=4/1/1/1, CLK_DIV=1, DATA_LATENCY=0, pixel_in=12'hFFF -> rgb=F only for x 0..7 of y 0..3; hsync low at x 10..11; 14-clk line, 98-clk frame.
- Same small set with DATA_LATENCY=2; source returns {4'h0, req_y[3:0], req_x[3:0]} through 2 tick registers -> pins show red=x, green=y with no skew relative to hsync/line_start.
- SYNC_POL=1 -> hsync/vsync idle low and high only in sync windows; reset value 0.
- Assert reset at (x=5,y=2) mid-line -> all outputs idle immediately; after release, the first frame_start is on the first pix_tick + DATA_LATENCY.
- Drop enable for 3 clk mid-frame, CLK_DIV=4 -> outputs idle, the next pix_tick arrives 4 clk after enable rises, and counters restart at 0.
